// File: rtl/core_seq_pkg.sv
// Shared types and sizing for the MAC-core sequencer.
package core_seq_pkg;

  localparam int DEPTH     = 32;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int LEN_W     = ADDR_W + 1;
  localparam int FLUSH_LAT = 3;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RUN   = 2'd1,
    OP_DRAIN = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  // Zero length means one entry; anything past the matrix depth is capped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) return LEN_W'(1);
    if (len > LEN_W'(DEPTH)) return LEN_W'(DEPTH);
    return len;
  endfunction

endpackage

// File: rtl/core_seq_perf.sv
// Saturating busy/stall cycle counters for the sequencer; 1-cycle update latency.
module core_seq_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] perf_busy,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
      if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Sequencer driving LOAD/RUN/DRAIN on a chain of NCORE MAC cores; one command at a time.
// Optional perf counters are built when CORE_SEQ_PERF_EN is defined.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int NCORE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [63:0]       wr_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [31:0]       d_data,
  output logic              core_init,
  output logic              core_write,
  output logic              core_ws,
  output logic              core_exec,
  output logic              core_outr,
  output logic              core_update,
  output logic [ADDR_W-1:0] core_wa,
  output logic [ADDR_W-1:0] core_ra,
  output logic [63:0]       core_wd,
  output logic [31:0]       core_d,
  input  logic [31:0]       core_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              busy
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
`endif
);

  localparam int K_W = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCORE - 1);

  state_e             state;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_nxt;
  logic               phase;
  logic [K_W-1:0]     kcnt;
  logic [63:0]        wd_q;
  logic [31:0]        d_q;

  logic load_fire;
  logic run_fire;
  logic drain_fire;

  assign cnt_nxt    = cnt + LEN_W'(1);
  assign load_fire  = (state == ST_LOAD) && !phase && wr_valid;
  assign run_fire   = (state == ST_RUN) && d_valid;
  assign drain_fire = (state == ST_DRAIN) && res_ready;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign wr_ready   = (state == ST_LOAD) && !phase;
  assign d_ready    = (state == ST_RUN);
  assign res_valid  = (state == ST_DRAIN);
  assign res_data   = core_acc;

  // The first half of a beat is written in its acceptance cycle, so the
  // bus shows the live beat then and the captured copy on the second half.
  assign core_write = load_fire || ((state == ST_LOAD) && phase);
  assign core_ws    = (state == ST_LOAD) && phase;
  assign core_wd    = load_fire ? wr_data : wd_q;
  assign core_wa    = addr;
  assign core_ra    = addr;
  assign core_init  = (state == ST_INIT);
  assign core_exec  = run_fire;
  assign core_d     = d_q;
  assign core_outr  = drain_fire;
  assign core_update = (state == ST_DRAIN) && (kcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      phase <= 1'b0;
      kcnt  <= '0;
      wd_q  <= '0;
      d_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_base;
            len   <= clamp_len(cmd_len);
            cnt   <= '0;
            phase <= 1'b0;
            kcnt  <= '0;
            case (op_e'(cmd_op))
              OP_LOAD:  state <= ST_LOAD;
              OP_RUN:   state <= ST_INIT;
              OP_DRAIN: state <= ST_DRAIN;
              default:  state <= ST_IDLE;
            endcase
          end
        end

        ST_LOAD: begin
          if (phase) begin
            addr  <= addr + ADDR_W'(1);
            cnt   <= cnt_nxt;
            phase <= 1'b0;
            if (cnt_nxt == len) state <= ST_IDLE;
          end else if (wr_valid) begin
            wd_q <= wr_data;
            addr <= addr + ADDR_W'(1);
            cnt  <= cnt_nxt;
            // An odd length ends on the lower half of the last beat.
            if (cnt_nxt == len) begin
              state <= ST_IDLE;
            end else begin
              phase <= 1'b1;
            end
          end
        end

        ST_INIT: state <= ST_RUN;

        ST_RUN: begin
          if (d_valid) begin
            d_q  <= d_data;
            addr <= addr + ADDR_W'(1);
            cnt  <= cnt_nxt;
            if (cnt_nxt == len) begin
              state <= ST_FLUSH;
              cnt   <= '0;
            end
          end
        end

        ST_FLUSH: begin
          if (cnt == LEN_W'(FLUSH_LAT - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        ST_DRAIN: begin
          if (res_ready) begin
            kcnt <= kcnt + K_W'(1);
            if (kcnt == K_LAST) begin
              state <= ST_IDLE;
              kcnt  <= '0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CORE_SEQ_PERF_EN
  logic stall;

  // A second-half write cycle is not a stall: no beat is wanted then.
  assign stall = ((state == ST_LOAD) && !phase && !wr_valid) ||
                 ((state == ST_RUN) && !d_valid) ||
                 ((state == ST_DRAIN) && !res_ready);

  core_seq_perf u_perf (
    .clk        (clk),
    .reset      (reset),
    .busy       (busy),
    .stall      (stall),
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall)
  );
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq with a behavioural model of a 4-core MAC chain.
module tb_core_seq;
  import core_seq_pkg::*;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_base = '0;
  logic [5:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [63:0] wr_data = '0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic [31:0] d_data = '0;
  logic        core_init, core_write, core_ws, core_exec, core_outr, core_update;
  logic [4:0]  core_wa, core_ra;
  logic [63:0] core_wd;
  logic [31:0] core_d;
  logic [31:0] core_acc;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  always #5 clk = ~clk;

  core_seq #(.NCORE(NC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .core_init(core_init), .core_write(core_write), .core_ws(core_ws),
    .core_exec(core_exec), .core_outr(core_outr), .core_update(core_update),
    .core_wa(core_wa), .core_ra(core_ra), .core_wd(core_wd), .core_d(core_d),
    .core_acc(core_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
`ifdef CORE_SEQ_PERF_EN
    , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
  );

  // IEEE single <-> real, exact for the normal values used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Core chain model: all cores see the same controls, so they hold equal sums.
  logic [31:0] mem [DEPTH];
  logic [31:0] sh [NC];
  logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [31:0] w1 = '0;
  real         p2 = 0.0, p3 = 0.0, acc = 0.0;
  int          cyc = 0, n_wr = 0, n_beat = 0, n_exec = 0, n_viol = 0;
  int          init_cyc = 0, fexec_cyc = 0;
  logic        exec_seen = 1'b0;
  logic [4:0]  log_wa [64];
  logic        log_ws [64];
  logic [31:0] log_wv [64];

  assign core_acc = core_update ? r2f(acc) : sh[NC-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_write) begin
      mem[core_wa] <= core_ws ? core_wd[63:32] : core_wd[31:0];
      log_wa[n_wr[5:0]] <= core_wa;
      log_ws[n_wr[5:0]] <= core_ws;
      log_wv[n_wr[5:0]] <= core_ws ? core_wd[63:32] : core_wd[31:0];
      n_wr <= n_wr + 1;
    end
    if (wr_valid && wr_ready) n_beat <= n_beat + 1;
    if ((core_write && core_exec) || (core_outr && !res_valid)) n_viol <= n_viol + 1;
    if (core_exec) begin
      n_exec <= n_exec + 1;
      if (!exec_seen) begin
        fexec_cyc <= cyc;
        exec_seen <= 1'b1;
      end
    end
    v1 <= core_exec;
    w1 <= mem[core_ra];
    v2 <= v1;
    p2 <= f2r(w1) * f2r(core_d);
    v3 <= v2;
    p3 <= p2;
    if (v3) acc <= acc + p3;
    if (core_init) begin
      init_cyc  <= cyc;
      exec_seen <= 1'b0;
      acc       <= 0.0;
    end
    if (core_outr) begin
      for (int i = 0; i < NC; i++)
        sh[i] <= core_update ? r2f(acc) : ((i == 0) ? 32'd0 : sh[i-1]);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called and returning at 1 ns after a rising edge; returns in cycle 0 of the command.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] base, input logic [5:0] len);
    int t;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
      tick();
    end
    chk("cmd_accept", t < 100, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [63:0] beats [4];

  task automatic load_stream(input int nb, output int bcyc);
    int i = 0;
    logic fired;
    bcyc = 0;
    wr_valid = 1'b1;
    wr_data  = beats[0];
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy) break;
      bcyc++;
      fired = wr_ready && wr_valid;
      tick();
      if (fired) begin
        i++;
        if (i < nb) wr_data = beats[i];
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    chk("load_done", busy, 0);
    tick();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [4:0] wa,
                         input logic ws, input logic [31:0] v);
    chk(tag, {log_wa[idx[5:0]], log_ws[idx[5:0]], log_wv[idx[5:0]]}, {wa, ws, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, b0, e0, bc, acc_at, k, ob, dc, t;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", {cmd_ready, busy}, 2'b10);
    chk("rst_hs", {wr_ready, d_ready, res_valid}, 3'b000);
    chk("rst_strobes", {core_init, core_write, core_ws, core_exec, core_outr, core_update}, 6'd0);
    chk("rst_addr", {core_wa, core_ra}, 10'd0);
    chk("rst_wd", core_wd, 64'd0);
    chk("rst_d", core_d, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // LOAD that wraps from address 31 to 0.
    beats[0] = 64'h1111_1111_2222_2222;
    beats[1] = 64'h3333_3333_4444_4444;
    w0 = n_wr;
    send_cmd(OP_LOAD, 5'd30, 6'd4);
    load_stream(2, bc);
    chk("ldwrap_cycles", bc, 4);
    chk("ldwrap_writes", n_wr - w0, 4);
    chk_log("ldwrap_w0", w0 + 0, 5'd30, 1'b0, 32'h2222_2222);
    chk_log("ldwrap_w1", w0 + 1, 5'd31, 1'b1, 32'h1111_1111);
    chk_log("ldwrap_w2", w0 + 2, 5'd0,  1'b0, 32'h4444_4444);
    chk_log("ldwrap_w3", w0 + 3, 5'd1,  1'b1, 32'h3333_3333);

    // Odd length: two beats, three writes, last one lower half only.
    beats[0] = 64'hAAAA_AAAA_BBBB_BBBB;
    beats[1] = 64'hCCCC_CCCC_DDDD_DDDD;
    beats[2] = 64'hEEEE_EEEE_FFFF_FFFF;
    w0 = n_wr; b0 = n_beat;
    send_cmd(OP_LOAD, 5'd8, 6'd3);
    load_stream(3, bc);
    chk("ld3_cycles", bc, 3);
    chk("ld3_beats", n_beat - b0, 2);
    chk("ld3_writes", n_wr - w0, 3);
    chk_log("ld3_last", w0 + 2, 5'd10, 1'b0, 32'hDDDD_DDDD);

    // Weights 1.0, 2.0, 3.0, 4.0 at addresses 0..3.
    beats[0] = {32'h4000_0000, 32'h3F80_0000};
    beats[1] = {32'h4080_0000, 32'h4040_0000};
    send_cmd(OP_LOAD, 5'd0, 6'd4);
    load_stream(2, bc);

    // Gapped RUN with a DRAIN already waiting on the command port.
    e0 = n_exec;
    send_cmd(OP_RUN, 5'd0, 6'd4);
    cmd_valid = 1'b1; cmd_op = OP_DRAIN; cmd_base = 5'd0; cmd_len = 6'd0;
    d_data = 32'h3F80_0000;
    acc_at = -1;
    for (t = 0; t < 60; t++) begin
      d_valid = (t % 2 == 1);
      @(negedge clk);
      if (cmd_ready) begin
        acc_at = t;
        break;
      end
      tick();
    end
    tick();
    cmd_valid = 1'b0;
    d_valid = 1'b0;
    chk("run_gap_ready_at", acc_at, 11);
    chk("run_gap_execs", n_exec - e0, 4);
    chk("run_init_lead", fexec_cyc - init_cyc, 1);

    // DRAIN with res_ready toggling 1,0,1,0...
    k = 0; ob = 0; dc = 0;
    for (t = 0; t < 40; t++) begin
      res_ready = (t % 2 == 0);
      @(negedge clk);
      if (!busy) break;
      dc++;
      if (core_outr !== res_ready) ob++;
      if (core_update !== (k == 0)) ob++;
      if (res_valid && res_ready) begin
        chk($sformatf("drain_res%0d", k), res_data, 32'h4120_0000);
        k++;
      end
      tick();
    end
    res_ready = 1'b0;
    tick();
    chk("drain_xfers", k, 4);
    chk("drain_cycles", dc, 7);
    chk("drain_ctl", ob, 0);

    // Unstalled RUN of length 2: INIT + 2 + FLUSH before the port reopens.
    send_cmd(OP_RUN, 5'd0, 6'd2);
    d_valid = 1'b1;
    for (t = 0; t < 40; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
      tick();
    end
    d_valid = 1'b0;
    tick();
    chk("run_nostall_cycles", t, 6);
    chk("strobe_exclusion", n_viol, 0);

    // Reset in the middle of a LOAD, then a fresh LOAD.
    beats[0] = 64'h5555_5555_5555_5555;
    send_cmd(OP_LOAD, 5'd10, 6'd6);
    wr_valid = 1'b1; wr_data = beats[0];
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_ctl", {busy, wr_ready, d_ready, res_valid, core_write, core_ws,
                       core_exec, core_init, core_outr, core_update, cmd_ready}, 11'b000_0000_0001);
    chk("rstmid_bus", {core_wa, core_ra, core_d}, 42'd0);
    chk("rstmid_wd", core_wd, 64'd0);
    tick();
    beats[0] = 64'h6666_6666_7777_7777;
    w0 = n_wr;
    send_cmd(OP_LOAD, 5'd2, 6'd2);
    load_stream(1, bc);
    chk("postrst_cycles", bc, 2);
    chk("postrst_writes", n_wr - w0, 2);
    chk_log("postrst_w0", w0 + 0, 5'd2, 1'b0, 32'h7777_7777);
    chk_log("postrst_w1", w0 + 1, 5'd3, 1'b1, 32'h6666_6666);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Sequencer for a chain of `NCORE` matrix-vector MAC cores.
- Accepts LOAD / RUN / DRAIN commands.
- Streams 64-bit weight beats into a core's 32-entry matrix.
- Issues `exec` beats with stride-aligned data.
- Waits out the core's 3-stage accumulate pipeline.
- Shifts accumulator results out of the `acc_in`→`acc` chain with backpressure.

Sits between the host DMA/AXI-stream glue and the core array; it is the only driver of the cores' control pins.

## Interface
- `NCORE`, 16: cores in the accumulator chain, i.e. results per DRAIN.
- `DEPTH`, 32: matrix entries per core; address width is `$clog2(DEPTH)`, which is 5.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; accepted when both are high.
- `cmd_op` in 2: 0 = LOAD, 1 = RUN, 2 = DRAIN, 3 = reserved (accepted, no-op).
- `cmd_base` in 5: first matrix address.
- `cmd_len` in 6: entry count, 1..32. A value of 0 is treated as 1; values >32 are clamped to 32.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in 64: weight beats, two entries per beat.
- `d_valid` in 1 / `d_ready` out 1 / `d_data` in 32: RUN operand stream.
- `core_init`, `core_write`, `core_ws`, `core_exec`, `core_outr`, `core_update` out 1: core controls.
- `core_wa`, `core_ra` out 5; `core_wd` out 64; `core_d` out 32: core address and data buses.
- `core_acc` in 32: `acc` of the chain-tail core.
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out 32: drained results.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States are IDLE, LOAD, INIT, RUN, FLUSH, DRAIN. `cmd_ready` is high only in IDLE.
- **IDLE**
  - LOAD → LOAD.
  - RUN → INIT.
  - DRAIN → DRAIN.
  - Reserved op → stays in IDLE.
  - Captures base, len and op at acceptance.
- **LOAD**
  - Each accepted beat produces two write cycles: `core_ws`=0 at `wa=addr`, then `core_ws`=1 at `wa=addr+1`.
  - `wr_ready` is high only on the first of the two cycles; `core_wd` is held for both.
  - Odd len: the final beat writes its lower half only.
  - Address wraps mod 32.
  - Returns to IDLE after len writes.
- **INIT**: one cycle with `core_init`=1, then → RUN. `core_init` always precedes the first `core_exec` by ≥1 cycle, so the core's delayed init never coincides with its first accumulate.
- **RUN**
  - `d_ready`=1.
  - Each accepted `d` beat drives `core_exec`=1 with `core_ra`=addr that cycle.
  - `core_d` is the beat data registered by one cycle, so it aligns with the core's exec1 capture.
  - No beat means `core_exec`=0 and the address holds.
  - After len beats → FLUSH.
- **FLUSH**: 3 cycles (`FLUSH_LAT`) with no exec, then → IDLE.
- **DRAIN**
  - Results are counted k = 0..NCORE-1.
  - `res_data`=`core_acc` (combinational); `res_valid`=1.
  - k=0: `core_update`=1; `core_outr` = `res_ready`.
  - k>0: `core_update`=0; `core_outr` = `res_ready`.
  - k advances only on `res_valid`&&`res_ready`.
  - Returns to IDLE after NCORE transfers.
- `core_write` and `core_exec` are never high in the same cycle; `core_outr` never fires outside DRAIN.
- RUN accumulates into whatever init cleared. A DRAIN without a prior RUN returns stale or zero values; this is legal.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - All `core_*` strobes 0; `core_wa`, `core_ra`, `core_wd`, `core_d` = 0.
  - `res_valid`=0, `wr_ready`=0, `d_ready`=0, `busy`=0.
  - State = IDLE; all counters = 0.
- `reset` mid-operation: return to IDLE next cycle. Core matrix contents are unaffected; partial accumulator contents are undefined.
- LOAD of len L takes L cycles after acceptance, with no bubbles at full `wr_valid`.
- RUN of len L with no stalls:
  - INIT(1) + L + FLUSH(3) cycles.
  - `cmd_ready` returns at cycle L+5 after acceptance.
  - The accumulator is valid when FLUSH exits.
- DRAIN: NCORE cycles at full `res_ready`; `res_valid` rises the cycle after acceptance.
- A command is accepted on the same edge the state leaves IDLE; back-to-back commands incur one IDLE cycle.

## Configuration
- `CORE_SEQ_PERF_EN` defined:
  - Adds outputs `perf_busy` [31:0] and `perf_stall` [31:0].
  - `perf_busy` counts cycles with `busy`.
  - `perf_stall` counts cycles in LOAD/RUN/DRAIN where the relevant valid/ready handshake did not fire.
  - Both saturate at all-ones and clear on `reset`.
- Undefined: no ports, no counters.

## Structure
- `core_seq_pkg` holds:
  - `op_e` (LOAD/RUN/DRAIN/RSVD).
  - `state_e`.
  - `localparam FLUSH_LAT = 3`.
  - `ADDR_W`, `LEN_W`.
- One sub-module, `core_seq_perf`, holds the two saturating counters and is instantiated only under `CORE_SEQ_PERF_EN`.

## Test plan
- LOAD base=30 len=4, beats 64'h1111_1111_2222_2222 and 64'h3333_3333_4444_4444 -> writes in order:
  - wa=30 gets 32'h2222_2222
  - wa=31 gets 32'h1111_1111
  - wa=0 gets 32'h3333_3333's partner lower word 32'h4444_4444
  - wa=1 gets 32'h3333_3333
  - Covers address wrap.
- LOAD len=3 -> exactly 2 beats accepted and 3 `core_write` pulses; the final pulse has `ws`=0.
- RUN base=0 len=4 with weights 1.0,2.0,3.0,4.0, d=1.0 each, `d_valid` gapped every other cycle:
  - `core_exec` count is 4.
  - init leads the first exec.
  - Tail accumulator reads 10.0 (32'h4120_0000) after DRAIN.
- DRAIN NCORE=4 with `res_ready` toggling 1,0,1,0… -> exactly 4 transfers; `core_update` high only during k=0; `core_outr` mirrors `res_ready`.
- `cmd_valid` during RUN -> `cmd_ready`=0; the command is accepted the cycle after FLUSH ends.
- `reset` asserted mid-LOAD -> next cycle all outputs are at reset values; a new LOAD then proceeds normally.
